// File: rtl/h2o_accum.sv
// h2o_accum: sums N_TERMS Q16.15 hidden-to-output products plus a bias and
// emits one saturated pre-activation per vector on a valid/ready interface.
`default_nettype none

module h2o_accum #(
  parameter int                        N_TERMS = 20,
  parameter int                        DATA_W  = 32,
  parameter int                        ACC_W   = 40,
  parameter logic signed [DATA_W-1:0]  BIAS    = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     y_valid,
  input  logic                     y_ready,
  output logic signed [DATA_W-1:0] y_data,
  output logic                     y_sat,
  output logic                     y_err_len,
  output logic                     busy
);

  localparam int CNT_W = $clog2(N_TERMS);

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(N_TERMS - 1);
  localparam logic signed [ACC_W-1:0] ACC_INIT = ACC_W'(BIAS);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

  logic [0:0]               state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     in_ready_q, in_ready_d;
  logic signed [DATA_W-1:0] y_data_q, y_data_d;
  logic                     y_sat_q, y_sat_d;
  logic                     y_err_q, y_err_d;

  logic signed [ACC_W-1:0]  in_ext;
  logic signed [ACC_W-1:0]  sum;
  logic                     accept;
  logic                     cnt_at_last;

  assign in_ext      = ACC_W'(in_data);
  assign sum         = acc_q + in_ext;
  assign accept      = in_valid & in_ready_q;
  assign cnt_at_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    y_data_d = y_data_q;
    y_sat_d  = y_sat_q;
    y_err_d  = y_err_q;

    case (state_q)
      ST_ACC: begin
        if (accept) begin
          if (in_last || cnt_at_last) begin
            // Accumulator is wide enough never to wrap; clip only here.
            if (sum > SAT_MAX) begin
              y_data_d = SAT_MAX[DATA_W-1:0];
              y_sat_d  = 1'b1;
            end else if (sum < SAT_MIN) begin
              y_data_d = SAT_MIN[DATA_W-1:0];
              y_sat_d  = 1'b1;
            end else begin
              y_data_d = sum[DATA_W-1:0];
              y_sat_d  = 1'b0;
            end
            y_err_d = in_last ^ cnt_at_last;
            acc_d   = ACC_INIT;
            cnt_d   = '0;
            state_d = ST_HOLD;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        if (y_ready) begin
          state_d = ST_ACC;
        end
      end
    endcase

    // Registered so in_ready is low straight out of reset and for one bubble after each result.
    in_ready_d = (state_d == ST_ACC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACC;
      acc_q      <= ACC_INIT;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      y_data_q   <= '0;
      y_sat_q    <= 1'b0;
      y_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      y_data_q   <= y_data_d;
      y_sat_q    <= y_sat_d;
      y_err_q    <= y_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign y_valid   = (state_q == ST_HOLD);
  assign y_data    = y_data_q;
  assign y_sat     = y_sat_q;
  assign y_err_len = y_err_q;
  assign busy      = (cnt_q != '0) | y_valid;

endmodule

`default_nettype wire

// File: tb/tb_h2o_accum.sv
// tb_h2o_accum: directed vectors into h2o_accum (BIAS = -16384), results checked
// by a scoreboard monitor that also applies output backpressure.
`default_nettype none

module tb_h2o_accum;

  localparam int                   N  = 20;
  localparam int                   DW = 32;
  localparam logic signed [DW-1:0] BIAS_P = -32'sd16384;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_last = 1'b0;
  logic                 y_ready = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic                 in_ready;
  logic                 y_valid;
  logic signed [DW-1:0] y_data;
  logic                 y_sat;
  logic                 y_err_len;
  logic                 busy;

  h2o_accum #(
    .N_TERMS (N),
    .DATA_W  (DW),
    .ACC_W   (40),
    .BIAS    (BIAS_P)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .y_data    (y_data),
    .y_sat     (y_sat),
    .y_err_len (y_err_len),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        sat;
    logic        err;
    int          bp;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] vec [0:31];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per result, checks hold stability, drives y_ready.
  logic        seen = 1'b0;
  logic [31:0] held_d;
  logic        held_s, held_e;
  int          hold_left = 0;
  exp_t        me;

  always @(negedge clk) begin
    if (!rst_n) begin
      seen    = 1'b0;
      y_ready = 1'b0;
    end else if (y_valid) begin
      if (!seen) begin
        seen   = 1'b1;
        held_d = y_data;
        held_s = y_sat;
        held_e = y_err_len;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got y_data 0x%08h with no result pending", y_data);
          hold_left = 0;
        end else begin
          me = sb.pop_front();
          chk("y_data", y_data, me.d);
          chk("y_sat", {31'd0, y_sat}, {31'd0, me.sat});
          chk("y_err_len", {31'd0, y_err_len}, {31'd0, me.err});
          hold_left = me.bp;
        end
      end else begin
        chk("hold_y_data", y_data, held_d);
        chk("hold_y_sat", {31'd0, y_sat}, {31'd0, held_s});
        chk("hold_y_err_len", {31'd0, y_err_len}, {31'd0, held_e});
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      if (hold_left > 0) begin
        y_ready = 1'b0;
        hold_left--;
      end else begin
        y_ready = 1'b1;
      end
    end else begin
      seen    = 1'b0;
      y_ready = 1'b0;
    end
  end

  // Drives vec[0..n-1]; last_at < 0 means in_last is never set.
  task automatic send(input int n, input int last_at, input logic [31:0] ed,
                      input logic es, input logic ee, input int bp,
                      input bit gaps, input bit push);
    exp_t e;
    int   waited;
    if (push) begin
      e.d = ed; e.sat = es; e.err = ee; e.bp = bp;
      sb.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      waited = 0;
      forever begin
        @(negedge clk);
        if (in_ready && (!gaps || $urandom_range(0, 1) == 1)) break;
        // Garbage on non-accept cycles; valid may even be high while in_ready is low.
        in_valid = in_ready ? 1'b0 : 1'($urandom_range(0, 1));
        in_data  = $urandom;
        in_last  = 1'($urandom_range(0, 1));
        waited++;
        if (waited > 200) begin
          n_cmp++;
          n_bad++;
          $display("FAIL in_ready_timeout: got in_ready %0b expected 1 within 200 cycles", in_ready);
          in_valid = 1'b0;
          return;
        end
      end
      in_valid = 1'b1;
      in_data  = vec[i];
      in_last  = (i == last_at);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
    if (push) begin
      chk("latency_y_valid", {31'd0, y_valid}, 32'd1);
      if (bp == 0) begin
        @(negedge clk);
        chk("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
        chk("y_valid_after_handshake", {31'd0, y_valid}, 32'd0);
      end
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_y_valid", {31'd0, y_valid}, 32'd0);
    chk("rst_y_data", y_data, 32'd0);
    chk("rst_y_sat", {31'd0, y_sat}, 32'd0);
    chk("rst_y_err_len", {31'd0, y_err_len}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    int drain;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Nominal: 20 x 1.0 -> 655360 - 16384.
    for (int i = 0; i < N; i++) vec[i] = 32'd32768;
    send(N, N - 1, 32'd638976, 1'b0, 1'b0, 0, 1'b0, 1'b1);

    // Alternating +1000/-3000 -> -20000 - 16384.
    for (int i = 0; i < N; i++) vec[i] = (i % 2 == 0) ? 32'd1000 : -32'sd3000;
    send(N, N - 1, -32'sd36384, 1'b0, 1'b0, 0, 1'b0, 1'b1);

    for (int i = 0; i < N; i++) vec[i] = 32'hFFFF_FFFF;
    send(N, N - 1, -32'sd16404, 1'b0, 1'b0, 0, 1'b0, 1'b1);

    // Saturation at both rails.
    for (int i = 0; i < N; i++) vec[i] = 32'h7FFF_FFFF;
    send(N, N - 1, 32'h7FFF_FFFF, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) vec[i] = 32'h8000_0000;
    send(N, N - 1, 32'h8000_0000, 1'b1, 1'b0, 0, 1'b0, 1'b1);

    // Gapped input with 5-cycle output backpressure: 20 x 3, then 1..20.
    for (int i = 0; i < N; i++) vec[i] = 32'd3;
    send(N, N - 1, -32'sd16324, 1'b0, 1'b0, 5, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) vec[i] = 32'(i + 1);
    send(N, N - 1, -32'sd16174, 1'b0, 1'b0, 5, 1'b1, 1'b1);

    // Early in_last on the 5th product of 100.
    for (int i = 0; i < N; i++) vec[i] = 32'd100;
    send(5, 4, -32'sd15884, 1'b0, 1'b1, 0, 1'b0, 1'b1);

    // in_last never set: vector closes on the 20th product with an error.
    for (int i = 0; i < N; i++) vec[i] = 32'd50;
    send(N, -1, -32'sd15384, 1'b0, 1'b1, 0, 1'b0, 1'b1);

    // Reset after 7 accepts; the partial vector must leave no output behind.
    for (int i = 0; i < N; i++) vec[i] = 32'd10;
    send(7, -1, 32'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("busy_mid_vector", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(N, N - 1, -32'sd16184, 1'b0, 1'b0, 0, 1'b0, 1'b1);

    drain = 0;
    while (sb.size() != 0 && drain < 100) begin
      @(negedge clk);
      drain++;
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
